// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped write-back L1 data cache.
package dcache_pkg;
  localparam int NUM_LINES = 16;
  localparam int LINE_W    = 256;
  localparam int ADDR_W    = 32;
  localparam int WORDS     = LINE_W / 32;
  localparam int OFF_W     = $clog2(LINE_W / 8);
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W    = OFF_W - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, REFILL_DONE} dc_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:2];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_W-1:0] i);
    return {t, i, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port
// (full-line refill, single-word store with dirty set, or dirty clear).
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [IDX_W-1:0]            r_idx,
  output logic                        r_valid,
  output logic                        r_dirty,
  output logic [TAG_W-1:0]            r_tag,
  output logic [WORDS-1:0][31:0]      r_line,
  input  logic [IDX_W-1:0]            w_idx,
  input  logic                        line_we,
  input  logic [TAG_W-1:0]            line_tag,
  input  logic [LINE_W-1:0]           line_data,
  input  logic                        word_we,
  input  logic [WSEL_W-1:0]           word_sel,
  input  logic [31:0]                 word_data,
  input  logic                        dirty_clr
);
  logic [NUM_LINES-1:0]                   valid_q, dirty_q;
  logic [NUM_LINES-1:0][TAG_W-1:0]        tag_q;
  logic [NUM_LINES-1:0][WORDS-1:0][31:0]  data_q;

  assign r_valid = valid_q[r_idx];
  assign r_dirty = dirty_q[r_idx];
  assign r_tag   = tag_q[r_idx];
  assign r_line  = data_q[r_idx];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[w_idx] <= 1'b1;
      dirty_q[w_idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[w_idx] <= 1'b1;
    end else if (dirty_clr) begin
      dirty_q[w_idx] <= 1'b0;
    end
  end

  // Payload arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      tag_q[w_idx]  <= line_tag;
      data_q[w_idx] <= line_data;
    end else if (word_we) begin
      data_q[w_idx][word_sel] <= word_data;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// L1 data cache controller: hit logic, miss FSM, memory port muxing.
// Optional DCACHE_STATS_EN adds saturating hit/miss/write-back counters.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
  output logic [31:0]       wb_cnt_o
`endif
);
  dc_state_e              state_q;
  logic                   r_valid, r_dirty, hit;
  logic [TAG_W-1:0]       r_tag, c_tag;
  logic [IDX_W-1:0]       c_idx, w_idx;
  logic [WSEL_W-1:0]      c_word;
  logic [WORDS-1:0][31:0] r_line;
  logic                   line_we, word_we, dirty_clr;
  logic [1:0]             unused_addr_lsb;

  assign unused_addr_lsb = cpu_addr_i[1:0];
  assign c_tag  = addr_tag(cpu_addr_i);
  assign c_idx  = addr_idx(cpu_addr_i);
  assign c_word = addr_word(cpu_addr_i);

  assign hit         = cpu_req_i & r_valid & (r_tag == c_tag) & (state_q == IDLE);
  assign cpu_stall_o = cpu_req_i & ~hit;
  assign cpu_data_o  = hit ? r_line[c_word] : 32'h0;

  // Line-level writes target the latched memory address so they stay correct
  // even if the CPU drops its request mid-miss.
  assign line_we   = (state_q == REFILL) & mem_ack_i;
  assign dirty_clr = (state_q == WRITEBACK) & mem_ack_i;
  assign word_we   = hit & cpu_write_i;
  assign w_idx     = word_we ? c_idx : addr_idx(mem_addr_o);

  dcache_sram u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .r_idx     (c_idx),
    .r_valid   (r_valid),
    .r_dirty   (r_dirty),
    .r_tag     (r_tag),
    .r_line    (r_line),
    .w_idx     (w_idx),
    .line_we   (line_we),
    .line_tag  (addr_tag(mem_addr_o)),
    .line_data (mem_data_i),
    .word_we   (word_we),
    .word_sel  (c_word),
    .word_data (cpu_data_i),
    .dirty_clr (dirty_clr)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req_i & ~hit) begin
          mem_enable_o <= 1'b1;
          if (r_valid & r_dirty) begin
            state_q     <= WRITEBACK;
            mem_write_o <= 1'b1;
            mem_addr_o  <= line_addr(r_tag, c_idx);
            mem_data_o  <= r_line;
          end else begin
            state_q     <= REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {cpu_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          mem_write_o <= 1'b0;
          if (cpu_req_i) begin
            state_q    <= REFILL;
            mem_addr_o <= {cpu_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end else begin
            state_q      <= IDLE;
            mem_enable_o <= 1'b0;
          end
        end
        REFILL: if (mem_ack_i) begin
          state_q      <= REFILL_DONE;
          mem_enable_o <= 1'b0;
        end
        REFILL_DONE: state_q <= IDLE;
        default:     state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic retry_q;

  // The access replayed right after a refill is not a first-try hit.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      retry_q    <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      retry_q <= (state_q == REFILL_DONE);
      if (hit & ~retry_q & (hit_cnt_o != '1))
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if ((state_q == IDLE) & cpu_req_i & ~hit & (miss_cnt_o != '1))
        miss_cnt_o <= miss_cnt_o + 32'd1;
      if (dirty_clr & (wb_cnt_o != '1))
        wb_cnt_o <= wb_cnt_o + 32'd1;
    end
  end
`endif
endmodule
